memory_bytewise: RTL and testbench

//  Parametrised single-port synchronous RAM; next generation of the 8-bit-address/16-bit-data memory.

---
 rtl/memory_bytewise_pkg.sv | 13 +
 rtl/memory_bytewise_if.sv | 29 ++
 rtl/memory_clear_seq.sv | 38 +++
 rtl/memory_bytewise.sv | 113 +++++++++++
 tb/tb_memory_bytewise.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bytewise_pkg.sv
// rtl/memory_bytewise_pkg.sv - shared constants for the byte-lane memory and its clear sequencer
package memory_bytewise_pkg;

    localparam int LANE_W = 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    function automatic int lane_count(input int data_w);
        return data_w / LANE_W;
    endfunction

endpackage

// File: rtl/memory_bytewise_if.sv
// rtl/memory_bytewise_if.sv - request/response bundle between the load/store unit and the memory
interface memory_bytewise_if
    import memory_bytewise_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);

    logic [ADDR_W-1:0]                  address;
    logic [DATA_W-1:0]                  data_in;
    logic [lane_count(DATA_W)-1:0]      byte_en;
    logic                               write_enable;
    logic                               read_enable;
    logic                               ready;
    logic [DATA_W-1:0]                  data_out;
    logic                               read_valid;
    logic                               addr_err;

    modport master (
        output address, data_in, byte_en, write_enable, read_enable,
        input  ready, data_out, read_valid, addr_err
    );

    modport slave (
        input  address, data_in, byte_en, write_enable, read_enable,
        output ready, data_out, read_valid, addr_err
    );

endinterface

// File: rtl/memory_clear_seq.sv
// rtl/memory_clear_seq.sv - post-reset clear counter and CLEAR/RUN state machine
module memory_clear_seq
    import memory_bytewise_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [0:0]        START_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_W   = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START_ST;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            if (cnt == LAST_W) begin
                state <= ST_RUN;
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;
    assign ready    = (state == ST_RUN);

endmodule

// File: rtl/memory_bytewise.sv
// rtl/memory_bytewise.sv - single-port RAM with byte lanes, 1/2-cycle read latency and post-reset clear
module memory_bytewise
    import memory_bytewise_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 8,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    memory_bytewise_if.slave  bus
);

    localparam int LANES = lane_count(DATA_W);

    if (DATA_W % LANE_W != 0) begin : g_bad_data_w
        $error("memory_bytewise: DATA_W must be a multiple of 8");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
        $error("memory_bytewise: READ_LAT must be 1 or 2");
    end
    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr_w
        $error("memory_bytewise: ADDR_W too narrow for DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;
    logic              in_range;
    logic              accept;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    memory_clear_seq #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign in_range = (32'(bus.address) < 32'(DEPTH));
    assign accept   = ready & (bus.write_enable | bus.read_enable);
    assign rd_acc   = accept & bus.read_enable;
    // Combinational read of the pre-edge contents gives read-before-write on a same-address collision.
    assign rd_word  = in_range ? mem[bus.address] : '0;

    // Clear and host writes never overlap: host requests are only accepted once ready is high.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (accept && bus.write_enable && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.byte_en[i]) begin
                    mem[bus.address][i*LANE_W +: LANE_W] <= bus.data_in[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    logic              s1_v;
    logic [DATA_W-1:0] s1_d;
    logic              err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_d  <= '0;
            err_q <= 1'b0;
        end else begin
            s1_v  <= rd_acc;
            err_q <= accept & ~in_range;
            if (rd_acc) begin
                s1_d <= rd_word;
            end
        end
    end

    if (READ_LAT == 1) begin : g_lat1
        assign bus.read_valid = s1_v;
        assign bus.data_out   = s1_d;
    end else begin : g_lat2
        logic              s2_v;
        logic [DATA_W-1:0] s2_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_v <= 1'b0;
                s2_d <= '0;
            end else begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_d <= s1_d;
                end
            end
        end

        assign bus.read_valid = s2_v;
        assign bus.data_out   = s2_d;
    end

    assign bus.ready    = ready;
    assign bus.addr_err = err_q;

endmodule

// File: tb/tb_memory_bytewise.sv
// tb/tb_memory_bytewise.sv - three memory configurations driven in lockstep against a behavioural model
module tb_memory_bytewise;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  s_addr = '0;
    logic [15:0] s_din  = '0;
    logic [1:0]  s_be   = '0;
    logic        s_we   = 1'b0;
    logic        s_re   = 1'b0;

    memory_bytewise_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();
    memory_bytewise_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
    memory_bytewise_if #(.ADDR_W(8), .DATA_W(16)) bus2 ();

    assign bus0.address = s_addr; assign bus0.data_in = s_din; assign bus0.byte_en = s_be;
    assign bus0.write_enable = s_we; assign bus0.read_enable = s_re;
    assign bus1.address = s_addr; assign bus1.data_in = s_din; assign bus1.byte_en = s_be;
    assign bus1.write_enable = s_we; assign bus1.read_enable = s_re;
    assign bus2.address = s_addr; assign bus2.data_in = s_din; assign bus2.byte_en = s_be;
    assign bus2.write_enable = s_we; assign bus2.read_enable = s_re;

    memory_bytewise #(.DATA_W(16), .DEPTH(256), .ADDR_W(8), .READ_LAT(1), .CLEAR_ON_RESET(1))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    memory_bytewise #(.DATA_W(16), .DEPTH(256), .ADDR_W(8), .READ_LAT(2), .CLEAR_ON_RESET(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    memory_bytewise #(.DATA_W(16), .DEPTH(200), .ADDR_W(8), .READ_LAT(1), .CLEAR_ON_RESET(1))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    logic        d_ready [3];
    logic [15:0] d_dout  [3];
    logic        d_rv    [3];
    logic        d_err   [3];

    assign d_ready[0] = bus0.ready; assign d_dout[0] = bus0.data_out;
    assign d_rv[0] = bus0.read_valid; assign d_err[0] = bus0.addr_err;
    assign d_ready[1] = bus1.ready; assign d_dout[1] = bus1.data_out;
    assign d_rv[1] = bus1.read_valid; assign d_err[1] = bus1.addr_err;
    assign d_ready[2] = bus2.ready; assign d_dout[2] = bus2.data_out;
    assign d_rv[2] = bus2.read_valid; assign d_err[2] = bus2.addr_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 2) ? 200 : 256;
    endfunction

    function automatic int lat(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Behavioural model: word array, edges-since-release counter, and one-slot delayed result for latency 2.
    logic [15:0] m_mem   [3][256];
    int          m_n     [3];
    logic        m_ready [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_dout  [3] = '{16'h0, 16'h0, 16'h0};
    logic        m_rv    [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_err   [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_sv    [3];
    logic [15:0] m_sd    [3];

    task automatic model_step();
        logic        acc;
        logic [15:0] rd;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_n[k] = 0; m_ready[k] = 1'b0; m_dout[k] = 16'h0;
                m_rv[k] = 1'b0; m_err[k] = 1'b0; m_sv[k] = 1'b0;
            end else begin
                acc = m_ready[k] && (s_we || s_re);
                rd  = (int'(s_addr) < dep(k)) ? m_mem[k][s_addr] : 16'h0;
                m_rv[k] = m_sv[k];
                if (m_sv[k]) m_dout[k] = m_sd[k];
                m_sv[k]  = 1'b0;
                m_err[k] = acc && (int'(s_addr) >= dep(k));
                if (acc && s_re) begin
                    if (lat(k) == 1) begin
                        m_rv[k] = 1'b1; m_dout[k] = rd;
                    end else begin
                        m_sv[k] = 1'b1; m_sd[k] = rd;
                    end
                end
                if (acc && s_we && int'(s_addr) < dep(k)) begin
                    if (s_be[0]) m_mem[k][s_addr][7:0]  = s_din[7:0];
                    if (s_be[1]) m_mem[k][s_addr][15:8] = s_din[15:8];
                end
                if (!m_ready[k]) begin
                    m_n[k]++;
                    if (m_n[k] == dep(k)) begin
                        for (int a = 0; a < 256; a++) m_mem[k][a] = 16'h0;
                        m_ready[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ready[%0d]", k), 32'(d_ready[k]), 32'(m_ready[k]));
            chk($sformatf("read_valid[%0d]", k), 32'(d_rv[k]), 32'(m_rv[k]));
            chk($sformatf("addr_err[%0d]", k), 32'(d_err[k]), 32'(m_err[k]));
            chk($sformatf("data_out[%0d]", k), 32'(d_dout[k]), 32'(m_dout[k]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic re, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
        step();
        s_we = we; s_re = re; s_addr = a; s_din = d; s_be = be;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
    endtask

    task automatic release_and_count(input string tag);
        int first [3];
        int c;
        first = '{-1, -1, -1};
        c = 0;
        rst = 1'b0;
        while ((first[0] < 0 || first[1] < 0 || first[2] < 0) && c < 400) begin
            @(posedge clk);
            #1;
            c++;
            for (int k = 0; k < 3; k++) begin
                if (first[k] < 0 && d_ready[k]) first[k] = c;
            end
        end
        chk({tag, "_ready_cycles0"}, 32'(first[0]), 32'd256);
        chk({tag, "_ready_cycles1"}, 32'(first[1]), 32'd256);
        chk({tag, "_ready_cycles2"}, 32'(first[2]), 32'd200);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_ready", 32'(d_ready[0]), 32'd0);
        chk("reset_dout", 32'(d_dout[1]), 32'd0);
        chk("reset_rv", 32'(d_rv[1]), 32'd0);
        chk("reset_err", 32'(d_err[2]), 32'd0);

        release_and_count("clr1");

        drv(1'b0, 1'b1, 8'h7F, 16'h0, 2'b00);
        idle();
        chk("t1_rv_lat1", 32'(d_rv[0]), 32'd1);
        chk("t1_dout_lat1", 32'(d_dout[0]), 32'h0000);
        chk("t1_rv_lat2_early", 32'(d_rv[1]), 32'd0);
        step();
        chk("t1_rv_lat2", 32'(d_rv[1]), 32'd1);
        chk("t1_rv_lat1_done", 32'(d_rv[0]), 32'd0);

        drv(1'b1, 1'b0, 8'h00, 16'h1234, 2'b11);
        drv(1'b0, 1'b1, 8'h00, 16'h0, 2'b00);
        idle();
        chk("t2_dout_lat1", 32'(d_dout[0]), 32'h1234);
        chk("t2_rv_lat2_early", 32'(d_rv[1]), 32'd0);
        step();
        chk("t2_dout_lat2", 32'(d_dout[1]), 32'h1234);
        chk("t2_rv_lat2", 32'(d_rv[1]), 32'd1);

        drv(1'b1, 1'b0, 8'h10, 16'hFFFF, 2'b11);
        drv(1'b1, 1'b0, 8'h10, 16'hAB00, 2'b10);
        drv(1'b0, 1'b1, 8'h10, 16'h0, 2'b00);
        idle();
        chk("t3_lane_merge", 32'(d_dout[0]), 32'hABFF);
        step();

        drv(1'b1, 1'b0, 8'h20, 16'h1111, 2'b11);
        drv(1'b1, 1'b1, 8'h20, 16'h5555, 2'b11);
        drv(1'b0, 1'b1, 8'h20, 16'h0, 2'b00);
        chk("t4_read_old", 32'(d_dout[0]), 32'h1111);
        idle();
        chk("t4_read_new", 32'(d_dout[0]), 32'h5555);
        step();

        drv(1'b1, 1'b0, 8'hC8, 16'hBEEF, 2'b11);
        drv(1'b0, 1'b1, 8'hC8, 16'h0, 2'b00);
        chk("t5_err_d200", 32'(d_err[2]), 32'd1);
        chk("t5_err_d256", 32'(d_err[0]), 32'd0);
        drv(1'b0, 1'b1, 8'h00, 16'h0, 2'b00);
        chk("t5_oor_dout", 32'(d_dout[2]), 32'h0000);
        chk("t5_oor_rv", 32'(d_rv[2]), 32'd1);
        chk("t5_inrange_dout", 32'(d_dout[0]), 32'hBEEF);
        drv(1'b1, 1'b0, 8'h00, 16'hFFFF, 2'b00);
        chk("t5_word0_kept", 32'(d_dout[2]), 32'h1234);
        drv(1'b0, 1'b1, 8'h00, 16'h0, 2'b00);
        drv(1'b0, 1'b1, 8'h10, 16'h0, 2'b00);
        chk("t5_noop_write", 32'(d_dout[0]), 32'h1234);
        drv(1'b0, 1'b1, 8'h20, 16'h0, 2'b00);
        drv(1'b0, 1'b1, 8'hFF, 16'h0, 2'b00);
        drv(1'b0, 1'b1, 8'hC8, 16'h0, 2'b00);
        idle();
        step();

        drv(1'b0, 1'b1, 8'h10, 16'h0, 2'b00);
        step();
        rst = 1'b1;
        s_re = 1'b0;
        step();
        chk("t6_inflight_lost", 32'(d_rv[1]), 32'd0);
        rst = 1'b0;
        s_re = 1'b1;
        s_addr = 8'h10;
        repeat (100) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        s_re = 1'b0;
        step();
        step();
        release_and_count("clr2");

        step();
        drv(1'b0, 1'b1, 8'h10, 16'h0, 2'b00);
        idle();
        chk("t6_cleared_word", 32'(d_dout[0]), 32'h0000);
        chk("t6_cleared_rv", 32'(d_rv[0]), 32'd1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
